// File: rtl/key_debounce_if.sv
`default_nettype none
// ============================================================================
//  Module   : key_debounce_if
//  Purpose  : Key bundle between the raw push-buttons, the debouncer and the
//             calculator entry FSM. The master drives raw keys and consumes
//             the debounced results; the slave is the debouncer.
//  Revision : 1.0  initial release
// ============================================================================
interface key_debounce_if #(
   parameter int N_KEYS = 5
);
   logic [N_KEYS-1:0] key_in;
   logic [N_KEYS-1:0] key_level;
   logic [N_KEYS-1:0] key_press;
   logic              key_valid;
   logic [2:0]        key_code;

   modport master (
      output key_in,
      input  key_level,
      input  key_press,
      input  key_valid,
      input  key_code
   );

   modport slave (
      input  key_in,
      output key_level,
      output key_press,
      output key_valid,
      output key_code
   );
endinterface
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : key_debounce
//  Purpose  : Push-button debouncer sampled on rising edges of the 100 Hz
//             clk_db strobe (treated as data). Produces debounced levels,
//             one-cycle press pulses, a valid strobe and a lowest-index code.
//  Options  : define KEY_AUTO_REPEAT_EN to build per-key hold counters that
//             re-issue presses while a key is held.
//  Revision : 1.0  initial release
// ============================================================================
module key_debounce #(
   parameter int N_KEYS       = 5,
   parameter int STABLE_TICKS = 3,
   parameter int REPEAT_DELAY = 50,
   parameter int REPEAT_RATE  = 10
) (
   input  wire logic      clk,
   input  wire logic      rst,
   input  wire logic      clk_db,
   key_debounce_if.slave  kb
);

   localparam logic [3:0] c_stable = 4'(STABLE_TICKS);

   // Reject configurations outside the supported parameter ranges
   generate
      if (N_KEYS < 1 || N_KEYS > 8 || STABLE_TICKS < 1 || STABLE_TICKS > 15 ||
          REPEAT_DELAY < 1 || REPEAT_DELAY > 255 ||
          REPEAT_RATE < 1 || REPEAT_RATE > 255) begin : g_bad_cfg
         $error("key_debounce: parameter out of range");
      end
   endgenerate

   logic [N_KEYS-1:0] sync1_q,     sync1_d;
   logic [N_KEYS-1:0] key_s_q,     key_s_d;
   logic              clk_db_q,    clk_db_d;
   logic [3:0]        cnt_q [N_KEYS];
   logic [3:0]        cnt_d [N_KEYS];
   logic [N_KEYS-1:0] key_level_q, key_level_d;
   logic [N_KEYS-1:0] key_press_q, key_press_d;
   logic              key_valid_q, key_valid_d;
   logic [2:0]        key_code_q,  key_code_d;
   logic              tick;
   logic [N_KEYS-1:0] rise;
   logic [N_KEYS-1:0] rep_hit;

   // clk_db_q resets high so a strobe already high at reset release is not a tick
   assign tick = clk_db & ~clk_db_q;
   assign rise = key_level_d & ~key_level_q;

   // Synchroniser, tick edge detect and per-key stability counters
   always_comb begin
      sync1_d     = kb.key_in;
      key_s_d     = sync1_q;
      clk_db_d    = clk_db;
      key_level_d = key_level_q;
      for (int i = 0; i < N_KEYS; i++) begin
         cnt_d[i] = cnt_q[i];
         if (tick) begin
            if (key_s_q[i] != key_level_q[i]) begin
               if (cnt_q[i] + 4'd1 == c_stable) begin
                  key_level_d[i] = ~key_level_q[i];
                  cnt_d[i]       = 4'd0;
               end else begin
                  cnt_d[i] = cnt_q[i] + 4'd1;
               end
            end else begin
               // any sample agreeing with the current level restarts the count
               cnt_d[i] = 4'd0;
            end
         end
      end
   end

`ifdef KEY_AUTO_REPEAT_EN
   localparam logic [7:0] c_delay  = 8'(REPEAT_DELAY);
   localparam logic [7:0] c_reload = 8'(REPEAT_DELAY - REPEAT_RATE);

   logic [7:0] hold_q [N_KEYS];
   logic [7:0] hold_d [N_KEYS];

   // Hold counters: idle while released or at a fresh press, count ticks while held
   always_comb begin
      for (int i = 0; i < N_KEYS; i++) begin
         hold_d[i]  = hold_q[i];
         rep_hit[i] = 1'b0;
         if (!key_level_d[i] || rise[i]) begin
            hold_d[i] = 8'd0;
         end else if (tick) begin
            if (hold_q[i] + 8'd1 == c_delay) begin
               // reloading keeps later repeats REPEAT_RATE ticks apart
               rep_hit[i] = 1'b1;
               hold_d[i]  = c_reload;
            end else begin
               hold_d[i] = hold_q[i] + 8'd1;
            end
         end
      end
   end

   // Hold counter registers
   always_ff @(posedge clk) begin
      for (int i = 0; i < N_KEYS; i++) begin
         if (rst) hold_q[i] <= 8'd0;
         else     hold_q[i] <= hold_d[i];
      end
   end
`else
   assign rep_hit = '0;
`endif

   // Press pulse, valid strobe and lowest-index key code
   always_comb begin
      key_press_d = rise | rep_hit;
      key_valid_d = |key_press_d;
      key_code_d  = key_code_q;
      for (int i = N_KEYS - 1; i >= 0; i--) begin
         if (key_press_d[i]) key_code_d = 3'(i);
      end
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q     <= '0;
         key_s_q     <= '0;
         clk_db_q    <= 1'b1;
         key_level_q <= '0;
         key_press_q <= '0;
         key_valid_q <= 1'b0;
         key_code_q  <= 3'd0;
         for (int i = 0; i < N_KEYS; i++) cnt_q[i] <= 4'd0;
      end else begin
         sync1_q     <= sync1_d;
         key_s_q     <= key_s_d;
         clk_db_q    <= clk_db_d;
         key_level_q <= key_level_d;
         key_press_q <= key_press_d;
         key_valid_q <= key_valid_d;
         key_code_q  <= key_code_d;
         for (int i = 0; i < N_KEYS; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   assign kb.key_level = key_level_q;
   assign kb.key_press = key_press_q;
   assign kb.key_valid = key_valid_q;
   assign kb.key_code  = key_code_q;

endmodule
`default_nettype wire
